fetch_prefetch_buffer: RTL and testbench
========================================

// Module: fetch_prefetch_buffer
// PURPOSE
// - Instruction prefetch stage between the 1-cycle-latency sync instruction RAM (dp_mem port A) and core fetch.
// - Issues sequential word reads and buffers returned instructions, each tagged with its PC, in a small FIFO.
// - Presents instructions to the core over a valid/ready handshake.
// - On a redirect: flushes buffered and in-flight data, then refetches from the new PC with no dead cycle.
// PARAMETERS
// - DEPTH     4             FIFO entries; power of 2, >= 2
// - RESET_PC  32'h8000_0000 first fetch address after reset
// PORTS
// - clk_i          in   1        clock, all state updates on posedge
// - rst_i          in   1        reset, synchronous, active-high
// - flush_i        in   1        redirect request (branch/trap/mret)
// - flush_pc_i     in   32       redirect target; bits [1:0] ignored (treated as 00)
// - mem_en_o       out  1        read request to instruction RAM
// - mem_addr_o     out  32       byte address of read; always word aligned
// - mem_rdata_i    in   32       read data, valid the cycle after mem_en_o
// - instr_valid_o  out  1        instr_o/instr_pc_o hold a valid instruction
// - instr_ready_i  in   1        core accepts instruction
// - instr_o        out  32       instruction word
// - instr_pc_o     out  32       PC of instr_o
// - occupancy_o    out  $clog2(DEPTH)+1   FIFO entry count (debug/perf)
// BEHAVIOUR
// - Reset (rst_i=1 at posedge):
//   - fetch_pc=RESET_PC; FIFO empty (rd/wr ptr 0, count 0); inflight_q=0.
//   - While rst_i=1: mem_en_o=0, instr_valid_o=0, occupancy_o=0.
//   - rst_i dominates flush_i.
//   - Reset mid-operation discards all buffered and in-flight data.
// - Issue: mem_en_o = !rst_i && (flush_i || (count + inflight_q) < DEPTH).
// - Addressing:
//   - mem_addr_o = flush_i ? {flush_pc_i[31:2],2'b00} : fetch_pc.
//   - On issue: fetch_pc <= mem_addr_o + 4, wrapping mod 2^32 (0xFFFF_FFFC -> 0).
// - Tracking: inflight_q <= issue && !rst_i; req_pc_q <= mem_addr_o on issue.
// - Response (inflight_q=1 and no flush_i): {mem_rdata_i, req_pc_q} is pushed to the FIFO.
// - Handshake:
//   - instr_valid_o = (count != 0) && !flush_i.
//   - Pop when instr_valid_o && instr_ready_i.
//   - instr_o/instr_pc_o come from the FIFO head; they hold stable while valid && !ready.
// - Simultaneous push and pop: count unchanged, both pointers advance, wrap mod DEPTH.
// - Overflow impossible: the issue rule reserves a slot per in-flight request.
// - Pop on empty: impossible by construction (valid=0).
// - Throughput: sustained 1 instr/cycle when ready held high.
// - Flush (flush_i=1, rst_i=0):
//   - FIFO cleared (count=0).
//   - Any response arriving this cycle is dropped.
//   - Any pop this cycle is void.
//   - The new PC is issued in the same cycle.
//   - fetch_pc <= target+4.
// - Latency, no bypass: issue at N, rdata at N+1, instr_valid_o at N+2.
// - After reset release (first cycle rst_i=0 = cycle 0): mem_en_o=1 with mem_addr_o=RESET_PC in cycle 0.
// - occupancy_o = count (registered).
// CONFIGURATION
// - Macro: FETCH_BYPASS_EN.
// - Defined:
//   - When count==0 && inflight_q && !flush_i: instr_valid_o=1, instr_o=mem_rdata_i, instr_pc_o=req_pc_q.
//   - If instr_ready_i in that cycle, the entry is consumed and not written to the FIFO; otherwise it is pushed.
//   - Latency issue->valid = 1 cycle.
//   - Issue rule unchanged.
// - Undefined:
//   - Responses are always written to the FIFO; valid comes only from FIFO state.
//   - Latency = 2 cycles.
//   - No combinational path from mem_rdata_i to outputs.
// TESTING
// - Reset release, ready=1, RAM holds 0x0000_0013 at 0x8000_0000 ->
//   - mem_addr_o 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles;
//   - first valid at cycle 2 (1 with FETCH_BYPASS_EN), instr_pc_o=0x8000_0000, then 1 instr/cycle.
// - ready=0 for 20 cycles after reset (DEPTH=4) ->
//   - occupancy_o saturates at 4, mem_en_o=0, no overflow;
//   - raising ready then yields PCs 0x8000_0000..0x8000_000C in order, no gaps/duplicates.
// - Steady stream, flush_i with flush_pc_i=0x8000_0102 ->
//   - same cycle mem_addr_o=0x8000_0100, occupancy_o=0 next cycle;
//   - next delivered instr_pc_o=0x8000_0100; stale in-flight word never delivered.
// - Back-to-back flushes to 0x8000_0040 then 0x8000_0080 ->
//   - only instructions from 0x8000_0080 onward appear.
// - fetch_pc=0xFFFF_FFFC via flush, ready=1 ->
//   - next issued mem_addr_o=0x0000_0000;
//   - delivered PCs 0xFFFF_FFFC, 0x0000_0000.
// - rst_i asserted while FIFO holds 3 entries and a request is in flight ->
//   - next cycle instr_valid_o=0, occupancy_o=0;
//   - after release, fetch restarts at RESET_PC; no pre-reset data delivered.

Source files
------------

// File: rtl/fetch_prefetch_buffer_if.sv
// Fetch-side bus of the prefetch buffer: redirect, instruction RAM port A and core handshake.
// The master modport is the prefetch buffer; the slave modport is the surrounding core/RAM.
interface fetch_prefetch_buffer_if #(
   parameter int unsigned DEPTH = 4
);
   logic                     flush_i;
   logic [31:0]              flush_pc_i;
   logic                     mem_en_o;
   logic [31:0]              mem_addr_o;
   logic [31:0]              mem_rdata_i;
   logic                     instr_valid_o;
   logic                     instr_ready_i;
   logic [31:0]              instr_o;
   logic [31:0]              instr_pc_o;
   logic [$clog2(DEPTH):0]   occupancy_o;

   modport master (
      input  flush_i, flush_pc_i, mem_rdata_i, instr_ready_i,
      output mem_en_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, occupancy_o
   );

   modport slave (
      output flush_i, flush_pc_i, mem_rdata_i, instr_ready_i,
      input  mem_en_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, occupancy_o
   );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: sequential reads from a 1-cycle sync RAM into a PC-tagged FIFO.
// Define FETCH_BYPASS_EN to forward a returning word straight to the core when the FIFO is empty.
module fetch_prefetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   fetch_prefetch_buffer_if.master bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_req_pc;
   logic          r_inflight;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_data [DEPTH];
   logic [31:0]   r_pcs  [DEPTH];

   logic          w_empty;
   logic [CW:0]   w_pending;
   logic          w_issue;
   logic [31:0]   w_addr;
   logic          w_valid;
   logic          w_pop;
   logic          w_push;
   logic          w_fifo_pop;

   assign w_empty   = (r_count == '0);
   // Each in-flight request already owns a FIFO slot, so the FIFO cannot overflow.
   assign w_pending = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_issue   = !rst_i && (bus.flush_i || (w_pending < (CW+1)'(DEPTH)));
   assign w_addr    = bus.flush_i ? {bus.flush_pc_i[31:2], 2'b00} : r_fetch_pc;

`ifdef FETCH_BYPASS_EN
   logic w_bypass;
   assign w_bypass       = w_empty && r_inflight;
   assign w_valid        = !rst_i && !bus.flush_i && (!w_empty || r_inflight);
   assign w_pop          = w_valid && bus.instr_ready_i;
   assign w_push         = r_inflight && !bus.flush_i && !(w_bypass && bus.instr_ready_i);
   assign bus.instr_o    = w_bypass ? bus.mem_rdata_i : r_data[r_rptr];
   assign bus.instr_pc_o = w_bypass ? r_req_pc : r_pcs[r_rptr];
`else
   assign w_valid        = !rst_i && !bus.flush_i && !w_empty;
   assign w_pop          = w_valid && bus.instr_ready_i;
   assign w_push         = r_inflight && !bus.flush_i;
   assign bus.instr_o    = r_data[r_rptr];
   assign bus.instr_pc_o = r_pcs[r_rptr];
`endif

   assign w_fifo_pop        = w_pop && !w_empty;
   assign bus.mem_en_o      = w_issue;
   assign bus.mem_addr_o    = w_addr;
   assign bus.instr_valid_o = w_valid;
   assign bus.occupancy_o   = r_count;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_fetch_pc <= w_addr + 32'd4;
            r_req_pc   <= w_addr;
         end
         // A redirect discards the FIFO and the response landing this cycle.
         if (bus.flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push)     r_wptr <= r_wptr + 1'b1;
            if (w_fifo_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_fifo_pop);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && w_push) begin
         r_data[r_wptr] <= bus.mem_rdata_i;
         r_pcs[r_wptr]  <= r_req_pc;
      end
   end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: directed scenarios plus random ready/redirect traffic,
// with a PC-stream scoreboard refilled on every reset release or redirect.
module tb_fetch_prefetch_buffer;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h8000_0000;
`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   fetch_prefetch_buffer_if #(.DEPTH(DEPTH)) bus ();

   fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return (a == RPC) ? 32'h0000_0013 : ((a * 32'h9E37_79B9) ^ 32'h0BAD_F00D);
   endfunction

   // Synchronous instruction RAM, one cycle read latency.
   always @(posedge clk_i)
      if (bus.mem_en_o) bus.mem_rdata_i <= ram_word(bus.mem_addr_o);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Expected delivery order after a redirect: sequential words from the aligned target.
   task automatic redirect(input logic [31:0] pc);
      logic [31:0] base;
      base = {pc[31:2], 2'b00};
      exp_q.delete();
      for (int i = 0; i < 300; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   // Monitor: scoreboard pops on each handshake, plus hold-stable and occupancy bound.
   logic        p_valid = 1'b0;
   logic        p_ready = 1'b0;
   logic [31:0] p_pc    = '0;
   logic [31:0] p_instr = '0;
   always @(negedge clk_i) begin
      logic [31:0] e;
      if (rst_i) begin
         p_valid = 1'b0;
      end else begin
         chk("occ_bound", 32'(bus.occupancy_o > DEPTH), 32'd0);
         if (bus.instr_valid_o && p_valid && !p_ready) begin
            chk("hold_pc", bus.instr_pc_o, p_pc);
            chk("hold_instr", bus.instr_o, p_instr);
         end
         if (bus.instr_valid_o && bus.instr_ready_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got pc %h expected no delivery", bus.instr_pc_o);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc", bus.instr_pc_o, e);
               chk("sb_instr", bus.instr_o, ram_word(e));
            end
         end
         p_valid = bus.instr_valid_o;
         p_ready = bus.instr_ready_i;
         p_pc    = bus.instr_pc_o;
         p_instr = bus.instr_o;
      end
   end

   initial begin
      logic        found;
      logic [31:0] tgt;
      int          since;
      bus.flush_i       = 1'b0;
      bus.flush_pc_i    = '0;
      bus.instr_ready_i = 1'b1;
      rst_i             = 1'b1;

      // Reset state
      repeat (3) step();
      settle();
      chk("rst_mem_en", 32'(bus.mem_en_o), 32'd0);
      chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
      chk("rst_occ", 32'(bus.occupancy_o), 32'd0);

      // Release with ready high: addresses, first-valid latency, throughput
      step();
      rst_i = 1'b0;
      redirect(RPC);
      settle();
      chk("c0_mem_en", 32'(bus.mem_en_o), 32'd1);
      chk("c0_addr", bus.mem_addr_o, RPC);
      chk("c0_valid", 32'(bus.instr_valid_o), 32'd0);
      step();
      settle();
      chk("c1_addr", bus.mem_addr_o, RPC + 32'd4);
      chk("c1_valid", 32'(bus.instr_valid_o), 32'(LAT == 1));
      step();
      settle();
      chk("c2_addr", bus.mem_addr_o, RPC + 32'd8);
      chk("c2_valid", 32'(bus.instr_valid_o), 32'd1);
      chk("c2_pc", bus.instr_pc_o, (LAT == 1) ? RPC + 32'd4 : RPC);
      for (int i = 0; i < 8; i++) begin
         step();
         settle();
         chk("throughput_valid", 32'(bus.instr_valid_o), 32'd1);
      end

      // Saturation with ready low
      step();
      rst_i = 1'b1;
      exp_q.delete();
      step();
      rst_i = 1'b0;
      bus.instr_ready_i = 1'b0;
      redirect(RPC);
      repeat (20) step();
      settle();
      chk("sat_occ", 32'(bus.occupancy_o), 32'(DEPTH));
      chk("sat_mem_en", 32'(bus.mem_en_o), 32'd0);
      chk("sat_pc", bus.instr_pc_o, RPC);
      step();
      bus.instr_ready_i = 1'b1;
      repeat (12) step();

      // Redirect in a steady stream to a misaligned target
      bus.flush_i    = 1'b1;
      bus.flush_pc_i = 32'h8000_0102;
      redirect(32'h8000_0100);
      settle();
      chk("flush_addr", bus.mem_addr_o, 32'h8000_0100);
      chk("flush_mem_en", 32'(bus.mem_en_o), 32'd1);
      chk("flush_valid", 32'(bus.instr_valid_o), 32'd0);
      step();
      bus.flush_i = 1'b0;
      settle();
      chk("flush_occ", 32'(bus.occupancy_o), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         if (bus.instr_valid_o) found = 1'b1;
         else begin
            step();
            settle();
         end
      end
      chk("flush_first_valid", 32'(found), 32'd1);
      if (found) chk("flush_first_pc", bus.instr_pc_o, 32'h8000_0100);
      repeat (6) step();

      // Back-to-back redirects
      bus.flush_i    = 1'b1;
      bus.flush_pc_i = 32'h8000_0040;
      redirect(32'h8000_0040);
      step();
      bus.flush_pc_i = 32'h8000_0080;
      redirect(32'h8000_0080);
      step();
      bus.flush_i = 1'b0;
      repeat (10) step();

      // Address wrap at the top of the space
      bus.flush_i    = 1'b1;
      bus.flush_pc_i = 32'hFFFF_FFFC;
      redirect(32'hFFFF_FFFC);
      step();
      bus.flush_i = 1'b0;
      settle();
      chk("wrap_addr", bus.mem_addr_o, 32'h0000_0000);
      repeat (8) step();

      // Reset with three buffered entries and one request in flight
      bus.instr_ready_i = 1'b0;
      bus.flush_i       = 1'b1;
      bus.flush_pc_i    = 32'h8000_0200;
      redirect(32'h8000_0200);
      step();
      bus.flush_i = 1'b0;
      repeat (3) step();
      settle();
      chk("pre_rst_occ", 32'(bus.occupancy_o), 32'd3);
      rst_i = 1'b1;
      exp_q.delete();
      settle();
      chk("in_rst_valid", 32'(bus.instr_valid_o), 32'd0);
      chk("in_rst_mem_en", 32'(bus.mem_en_o), 32'd0);
      step();
      settle();
      chk("post_rst_occ", 32'(bus.occupancy_o), 32'd0);
      chk("post_rst_valid", 32'(bus.instr_valid_o), 32'd0);
      step();
      rst_i = 1'b0;
      bus.instr_ready_i = 1'b1;
      redirect(RPC);
      settle();
      chk("restart_addr", bus.mem_addr_o, RPC);
      repeat (10) step();

      // Random ready and redirect traffic
      since = 0;
      for (int i = 0; i < 600; i++) begin
         step();
         bus.instr_ready_i = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0 || since > 120) begin
            tgt            = $urandom;
            bus.flush_i    = 1'b1;
            bus.flush_pc_i = tgt;
            redirect(tgt);
            since = 0;
         end else begin
            bus.flush_i = 1'b0;
            since++;
         end
      end
      step();
      bus.flush_i       = 1'b0;
      bus.instr_ready_i = 1'b1;
      repeat (10) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
